// File: rtl/sim_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sim_mon_pkg
// Purpose  : Shared state encoding and defaults for the end-of-test monitor.
// Revision : 1.0 - initial release
// ============================================================================
package sim_mon_pkg;

  // Monitor life cycle: idle until enabled, run until the tohost PC has been
  // retired often enough, settle for the writeback lag, then hold the verdict.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } mon_state_e;

  // Address of the "write tohost" loop in the riscv-tests environment.
  localparam logic [31:0] PC_WRITE_TOHOST    = 32'h0000_0086;
  // riscv-tests leave 1 in x3 (gp) on success.
  localparam logic [31:0] PASS_VALUE_DEFAULT = 32'd1;
  // Settle counter width; covers the legal SETTLE range 1..15.
  localparam int          SETTLE_W           = 4;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter that sticks at all-ones instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, hold at all-ones, synchronous clear wins over inc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/sim_end_monitor.sv
`default_nettype none
// ============================================================================
// Module   : sim_end_monitor
// Purpose  : End-of-test monitor: counts cycles/retires, detects repeated
//            retirement at the tohost PCs, samples the result register and
//            reports a sticky pass/fail/timeout verdict.
// Revision : 1.0 - initial release
// ============================================================================
module sim_end_monitor
  import sim_mon_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int XLEN     = 32,
  parameter int CNT_W    = 32,
  parameter int NUM_TRIG = 2,
  parameter int HIT_W    = 8,
  parameter int SETTLE   = 2
) (
  input  logic                     clk,
  input  logic                     cpurst_n,
  input  logic                     clear,
  input  logic                     enable,
  input  logic [NUM_TRIG*PC_W-1:0] trig_pc_vec,
  input  logic [NUM_TRIG-1:0]      trig_en,
  input  logic [HIT_W-1:0]         hit_thresh,
  input  logic [CNT_W-1:0]         timeout_cycles,
  input  logic [XLEN-1:0]          pass_value,
  input  logic                     retire_valid,
  input  logic [PC_W-1:0]          retire_pc,
  input  logic [XLEN-1:0]          result_reg,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic                     timeout,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [CNT_W-1:0]         instret_count,
  output logic [HIT_W-1:0]         hit_count,
  output logic [XLEN-1:0]          result_snap
);

  mon_state_e          state, state_nx;
  logic [SETTLE_W-1:0] settle_cnt, settle_nx;
  logic                pass_nx, fail_nx, timeout_nx;
  logic [XLEN-1:0]     snap_nx;

  logic [NUM_TRIG-1:0] chan_match;
  logic                counting, hit, thresh_hit, wd_hit;
  logic [HIT_W-1:0]    thresh_eff;
  logic [HIT_W:0]      hit_plus1;
  logic [CNT_W-1:0]    cycle_next;

  // Per-channel PC comparators.
  generate
    for (genvar k = 0; k < NUM_TRIG; k++) begin : g_trig
      assign chan_match[k] = trig_en[k] && (retire_pc == trig_pc_vec[k*PC_W +: PC_W]);
    end
  endgenerate

  // Counting only while the test is live; several matching channels still
  // make a single hit.
  assign counting   = enable && ((state == ST_RUN) || (state == ST_SETTLE));
  assign hit        = counting && retire_valid && (|chan_match);
  assign thresh_eff = (hit_thresh == '0) ? HIT_W'(1) : hit_thresh;
  assign hit_plus1  = {1'b0, hit_count} + (HIT_W+1)'(1);
  assign thresh_hit = hit && (state == ST_RUN) && (hit_plus1 >= {1'b0, thresh_eff});

  // Watchdog looks at the value cycle_count takes on this edge.
  assign cycle_next = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
  assign wd_hit     = counting && (state == ST_RUN) && (timeout_cycles != '0) &&
                      (cycle_next >= timeout_cycles);

  assign busy = (state == ST_RUN) || (state == ST_SETTLE);
  assign done = (state == ST_DONE);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk(clk), .rst_n(cpurst_n), .clr(clear), .inc(counting), .count(cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instret_cnt (
    .clk(clk), .rst_n(cpurst_n), .clr(clear), .inc(counting && retire_valid),
    .count(instret_count)
  );

  sat_counter #(.W(HIT_W)) u_hit_cnt (
    .clk(clk), .rst_n(cpurst_n), .clr(clear), .inc(hit), .count(hit_count)
  );

  // State, settle counter and verdict registers.
  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      state       <= ST_IDLE;
      settle_cnt  <= '0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      result_snap <= '0;
    end else begin
      state       <= state_nx;
      settle_cnt  <= settle_nx;
      pass        <= pass_nx;
      fail        <= fail_nx;
      timeout     <= timeout_nx;
      result_snap <= snap_nx;
    end
  end

  // Next-state and verdict decisions; threshold beats watchdog on a tie.
  always_comb begin
    state_nx   = state;
    settle_nx  = settle_cnt;
    pass_nx    = pass;
    fail_nx    = fail;
    timeout_nx = timeout;
    snap_nx    = result_snap;
    if (clear) begin
      state_nx   = ST_IDLE;
      settle_nx  = '0;
      pass_nx    = 1'b0;
      fail_nx    = 1'b0;
      timeout_nx = 1'b0;
      snap_nx    = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) state_nx = ST_RUN;
        end
        ST_RUN: begin
          if (thresh_hit) begin
            state_nx  = ST_SETTLE;
            settle_nx = SETTLE_W'(SETTLE - 1);
          end else if (wd_hit) begin
            state_nx   = ST_DONE;
            timeout_nx = 1'b1;
            fail_nx    = 1'b1;
            snap_nx    = result_reg;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == '0) begin
            state_nx = ST_DONE;
            snap_nx  = result_reg;
            pass_nx  = (result_reg == pass_value);
            fail_nx  = (result_reg != pass_value);
          end else begin
            settle_nx = settle_cnt - SETTLE_W'(1);
          end
        end
        default: begin
          state_nx = state;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sim_end_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_sim_end_monitor
// Purpose  : Self-checking bench for sim_end_monitor with a trace-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sim_end_monitor;
  import sim_mon_pkg::*;

  localparam int MAXC   = 200;
  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        cpurst_n, clear, enable, retire_valid;
  logic [63:0] trig_pc_vec;
  logic [1:0]  trig_en;
  logic [7:0]  hit_thresh;
  logic [31:0] timeout_cycles, pass_value, retire_pc, result_reg;

  logic        busy, done, pass, fail, timeout;
  logic [31:0] cycle_count, instret_count, result_snap;
  logic [7:0]  hit_count;

  logic        s_busy, s_done, s_pass, s_fail, s_timeout;
  logic [3:0]  s_cycle, s_instret;
  logic [7:0]  s_hit;
  logic [31:0] s_snap;
  logic [3:0]  s_tmo = 4'd0;

  int errors = 0;
  int checks = 0;

  // Stimulus trace: one entry per clock edge.
  logic        st_en [MAXC];
  logic        st_val[MAXC];
  logic [31:0] st_pc [MAXC];
  logic [31:0] st_res[MAXC];
  int          n_cyc;

  // Model results.
  int          m_s, m_t, m_w, m_d, m_cyc, m_ins, m_hit;
  logic        m_pass, m_fail, m_to;
  logic [31:0] m_snap;

  always #5 clk = ~clk;

  sim_end_monitor #(.PC_W(32), .XLEN(32), .CNT_W(32), .NUM_TRIG(2), .HIT_W(8), .SETTLE(SETTLE)) dut (
    .clk(clk), .cpurst_n(cpurst_n), .clear(clear), .enable(enable),
    .trig_pc_vec(trig_pc_vec), .trig_en(trig_en), .hit_thresh(hit_thresh),
    .timeout_cycles(timeout_cycles), .pass_value(pass_value),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .result_reg(result_reg),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .cycle_count(cycle_count), .instret_count(instret_count),
    .hit_count(hit_count), .result_snap(result_snap)
  );

  sim_end_monitor #(.PC_W(32), .XLEN(32), .CNT_W(4), .NUM_TRIG(2), .HIT_W(8), .SETTLE(1)) dut_s (
    .clk(clk), .cpurst_n(cpurst_n), .clear(clear), .enable(enable),
    .trig_pc_vec(trig_pc_vec), .trig_en(trig_en), .hit_thresh(hit_thresh),
    .timeout_cycles(s_tmo), .pass_value(pass_value),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .result_reg(result_reg),
    .busy(s_busy), .done(s_done), .pass(s_pass), .fail(s_fail), .timeout(s_timeout),
    .cycle_count(s_cycle), .instret_count(s_instret),
    .hit_count(s_hit), .result_snap(s_snap)
  );

  function automatic bit is_trig(input logic [31:0] pc);
    bit m = 1'b0;
    for (int k = 0; k < 2; k++)
      if (trig_en[k] && pc == trig_pc_vec[k*32 +: 32]) m = 1'b1;
    return m;
  endfunction

  // Trace model: locate start edge, threshold edge, watchdog edge and
  // verdict edge from cumulative counts over the stimulus trace.
  task automatic model_run();
    int th;
    th = (hit_thresh == 8'd0) ? 1 : int'(hit_thresh);
    m_s = -1; m_t = -1; m_w = -1; m_d = -1;
    m_cyc = 0; m_ins = 0; m_hit = 0;
    for (int i = 0; i < n_cyc; i++) begin
      if (m_d >= 0) break;
      if (m_s < 0) begin
        if (st_en[i]) m_s = i;
        continue;
      end
      if (st_en[i]) begin
        m_cyc++;
        if (st_val[i]) m_ins++;
        if (st_val[i] && is_trig(st_pc[i])) begin
          if (m_hit < 255) m_hit++;
          if (m_t < 0 && m_hit >= th) m_t = i;
        end
        if (m_t < 0 && timeout_cycles != 0 && m_cyc >= int'(timeout_cycles)) begin
          m_w = i; m_d = i;
        end
      end
      if (m_t >= 0 && m_d < 0 && i == m_t + SETTLE) m_d = i;
    end
    m_snap = (m_d >= 0) ? st_res[m_d] : 32'd0;
    m_to   = (m_w >= 0);
    m_pass = (m_d >= 0) && !m_to && (st_res[m_d] == pass_value);
    m_fail = (m_d >= 0) && !m_pass;
  endtask

  task automatic fill_stim(input int n);
    n_cyc = n;
    for (int i = 0; i < MAXC; i++) begin
      st_en[i] = 1'b1; st_val[i] = 1'b1; st_pc[i] = 32'h90; st_res[i] = PASS_VALUE_DEFAULT;
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1; enable = 1'b0; retire_valid = 1'b0;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Play the trace, check busy/done after every edge and the final outputs.
  task automatic run_and_check(input string tag);
    bit exp_b, exp_dn;
    int e;
    model_run();
    for (int i = 0; i <= n_cyc; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = i - 1;
        exp_b  = (m_s >= 0) && (e >= m_s) && (m_d < 0 || e < m_d);
        exp_dn = (m_d >= 0) && (e >= m_d);
        checks++;
        if (busy !== exp_b || done !== exp_dn) begin
          errors++;
          $display("FAIL %s busy/done after edge %0d: got %b/%b expected %b/%b", tag, e, busy, done, exp_b, exp_dn);
        end
      end
      if (i < n_cyc) begin
        enable = st_en[i]; retire_valid = st_val[i]; retire_pc = st_pc[i]; result_reg = st_res[i];
      end else begin
        enable = 1'b0; retire_valid = 1'b0;
      end
    end
    checks++; if (cycle_count !== m_cyc) begin errors++; $display("FAIL %s cycle_count: got %0d expected %0d", tag, cycle_count, m_cyc); end
    checks++; if (instret_count !== m_ins) begin errors++; $display("FAIL %s instret_count: got %0d expected %0d", tag, instret_count, m_ins); end
    checks++; if (hit_count !== m_hit[7:0]) begin errors++; $display("FAIL %s hit_count: got %0d expected %0d", tag, hit_count, m_hit); end
    checks++; if (pass !== m_pass || fail !== m_fail || timeout !== m_to) begin
      errors++; $display("FAIL %s pass/fail/timeout: got %b%b%b expected %b%b%b", tag, pass, fail, timeout, m_pass, m_fail, m_to);
    end
    checks++; if (result_snap !== m_snap) begin errors++; $display("FAIL %s result_snap: got %h expected %h", tag, result_snap, m_snap); end
  endtask

  task automatic cfg(input logic [31:0] t0, input logic [31:0] t1, input logic [1:0] en,
                     input logic [7:0] th, input logic [31:0] tmo);
    trig_pc_vec = {t1, t0}; trig_en = en; hit_thresh = th; timeout_cycles = tmo;
    pass_value = PASS_VALUE_DEFAULT;
  endtask

  task automatic test_reset();
    cpurst_n = 1'b0; clear = 1'b0; enable = 1'b0; retire_valid = 1'b0;
    retire_pc = '0; result_reg = '0;
    cfg(PC_WRITE_TOHOST, 32'h200, 2'b01, 8'd8, 32'd0);
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, pass, fail, timeout} !== 5'b0 || cycle_count !== 0 || instret_count !== 0 ||
        hit_count !== 0 || result_snap !== 0) begin
      errors++; $display("FAIL reset_main: got flags %b%b%b%b%b cyc %0d", busy, done, pass, fail, timeout, cycle_count);
    end
    checks++;
    if ({s_busy, s_done, s_pass, s_fail, s_timeout} !== 5'b0 || s_cycle !== 0 || s_instret !== 0) begin
      errors++; $display("FAIL reset_small: got flags %b%b%b%b%b cyc %0d", s_busy, s_done, s_pass, s_fail, s_timeout, s_cycle);
    end
    cpurst_n = 1'b1;
  endtask

  task automatic pass_stim(input int n, input logic [31:0] res);
    fill_stim(n);
    for (int i = 0; i < n; i++) begin
      st_res[i] = res;
      if (i >= 2 && i <= 16 && (i % 2) == 0) st_pc[i] = PC_WRITE_TOHOST;
    end
  endtask

  task automatic test_pass_path();
    do_clear();
    cfg(PC_WRITE_TOHOST, 32'h200, 2'b01, 8'd8, 32'd0);
    pass_stim(24, 32'd1);
    run_and_check("pass_path");
    checks++; if (pass !== 1'b1 || hit_count !== 8'd8 || result_snap !== 32'd1) begin
      errors++; $display("FAIL pass_path_fixed: got pass %b hits %0d snap %0d required 1/8/1", pass, hit_count, result_snap);
    end
    // Retirements after DONE must not move anything.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); enable = 1'b1; retire_valid = 1'b1; retire_pc = PC_WRITE_TOHOST;
    end
    @(negedge clk); enable = 1'b0; retire_valid = 1'b0;
    checks++; if (instret_count !== m_ins || hit_count !== m_hit[7:0] || cycle_count !== m_cyc || done !== 1'b1) begin
      errors++; $display("FAIL done_freeze: got ins %0d hit %0d cyc %0d required %0d %0d %0d", instret_count, hit_count, cycle_count, m_ins, m_hit, m_cyc);
    end
  endtask

  task automatic test_fail_path();
    do_clear();
    cfg(PC_WRITE_TOHOST, 32'h200, 2'b01, 8'd8, 32'd0);
    pass_stim(24, 32'd5);
    run_and_check("fail_path");
    checks++; if (fail !== 1'b1 || pass !== 1'b0 || result_snap !== 32'd5) begin
      errors++; $display("FAIL fail_path_fixed: got fail %b pass %b snap %0d required 1/0/5", fail, pass, result_snap);
    end
  endtask

  task automatic test_watchdog();
    do_clear();
    cfg(PC_WRITE_TOHOST, 32'h200, 2'b00, 8'd8, 32'd100);
    fill_stim(110);
    run_and_check("watchdog");
    checks++; if (timeout !== 1'b1 || fail !== 1'b1 || cycle_count !== 32'd100) begin
      errors++; $display("FAIL watchdog_fixed: got to %b fail %b cyc %0d required 1/1/100", timeout, fail, cycle_count);
    end
    do_clear();
    cfg(PC_WRITE_TOHOST, 32'h200, 2'b01, 8'd8, 32'd100);
    fill_stim(106);
    for (int i = 93; i <= 100; i++) st_pc[i] = PC_WRITE_TOHOST;
    run_and_check("watchdog_tie");
    checks++; if (timeout !== 1'b0 || pass !== 1'b1) begin
      errors++; $display("FAIL watchdog_tie_fixed: got to %b pass %b required 0/1", timeout, pass);
    end
  endtask

  task automatic test_multi_channel();
    do_clear();
    cfg(PC_WRITE_TOHOST, 32'h200, 2'b11, 8'd3, 32'd0);
    fill_stim(15);
    st_pc[3] = 32'h86; st_pc[5] = 32'h200; st_pc[7] = 32'h86;
    run_and_check("multi_channel");
    checks++; if (done !== 1'b1 || hit_count !== 8'd3) begin
      errors++; $display("FAIL multi_channel_fixed: got done %b hits %0d required 1/3", done, hit_count);
    end
    do_clear();
    cfg(PC_WRITE_TOHOST, PC_WRITE_TOHOST, 2'b11, 8'd3, 32'd0);
    fill_stim(12);
    st_pc[2] = 32'h86; st_pc[4] = 32'h86; st_pc[6] = 32'h86;
    run_and_check("dual_match");
    checks++; if (hit_count !== 8'd3) begin
      errors++; $display("FAIL dual_match_fixed: got hits %0d required 3", hit_count);
    end
  endtask

  task automatic test_saturation();
    do_clear();
    cfg(PC_WRITE_TOHOST, 32'h200, 2'b00, 8'd8, 32'd0);
    fill_stim(21);
    run_and_check("saturation");
    checks++; if (s_cycle !== 4'd15 || s_instret !== 4'd15) begin
      errors++; $display("FAIL saturation_small: got cyc %0d ins %0d required 15/15", s_cycle, s_instret);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); enable = 1'b0; retire_valid = 1'b1;
    end
    @(negedge clk); retire_valid = 1'b0;
    checks++; if (cycle_count !== 32'd20 || instret_count !== 32'd20 || busy !== 1'b1 || s_cycle !== 4'd15) begin
      errors++; $display("FAIL enable_freeze: got cyc %0d ins %0d busy %b small %0d required 20/20/1/15", cycle_count, instret_count, busy, s_cycle);
    end
  endtask

  task automatic test_reset_clear();
    do_clear();
    cfg(PC_WRITE_TOHOST, 32'h200, 2'b01, 8'd8, 32'd0);
    pass_stim(18, 32'd1);
    run_and_check("pre_reset");
    cpurst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, pass, fail, timeout} !== 5'b0 || cycle_count !== 0 || instret_count !== 0 || hit_count !== 0) begin
      errors++; $display("FAIL reset_mid_settle: got flags %b%b%b%b%b cyc %0d hits %0d required zeros", busy, done, pass, fail, timeout, cycle_count, hit_count);
    end
    @(negedge clk); cpurst_n = 1'b1;
    pass_stim(22, 32'd1);
    run_and_check("pre_clear");
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0; enable = 1'b1;
    checks++; if (done !== 1'b0 || busy !== 1'b0 || cycle_count !== 0 || hit_count !== 0 || pass !== 1'b0 || result_snap !== 0) begin
      errors++; $display("FAIL clear_in_done: got done %b busy %b cyc %0d hits %0d pass %b", done, busy, cycle_count, hit_count, pass);
    end
    @(negedge clk); enable = 1'b0;
    checks++; if (busy !== 1'b1 || cycle_count !== 0) begin
      errors++; $display("FAIL restart_run: got busy %b cyc %0d required 1/0", busy, cycle_count);
    end
  endtask

  task automatic test_random();
    logic [31:0] pcs[4];
    pcs[0] = 32'h86; pcs[1] = 32'h200; pcs[2] = 32'h300; pcs[3] = 32'h40;
    for (int it = 0; it < 8; it++) begin
      do_clear();
      cfg(pcs[$urandom_range(0, 3)], pcs[$urandom_range(0, 3)], 2'($urandom_range(0, 3)),
          8'($urandom_range(0, 6)), ($urandom_range(0, 1) == 1) ? 32'($urandom_range(20, 120)) : 32'd0);
      fill_stim(150);
      for (int i = 0; i < 150; i++) begin
        st_en[i]  = ($urandom_range(0, 9) < 8);
        st_val[i] = ($urandom_range(0, 9) < 7);
        st_pc[i]  = pcs[$urandom_range(0, 3)];
        st_res[i] = ($urandom_range(0, 1) == 1) ? 32'd1 : $urandom;
      end
      run_and_check($sformatf("random_%0d", it));
    end
  endtask

  initial begin
    test_reset();
    test_pass_path();
    test_fail_path();
    test_watchdog();
    test_multi_channel();
    test_saturation();
    test_reset_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sim_end_monitor.md
Name: sim_end_monitor

Overview:
- Synthesisable, parametrised end-of-test monitor for the core. Replaces the fixed bench-side tohost counter and x3 check.
- Watches the decode-to-execute retire stream and counts cycles and retired instructions.
- Detects repeated retirement at any of NUM_TRIG programmable "write tohost" PCs, then samples the result register and declares pass or fail.
- Adds a cycle watchdog, saturating counters and a sticky status, so benches and FPGA builds share one termination mechanism.

Parameters:
- PC_W, 32, width of the retire PC and trigger PCs.
- XLEN, 32, width of the result register and pass value.
- CNT_W, 32, width of the cycle and instruction counters and the timeout.
- NUM_TRIG, 2, number of trigger-PC channels.
- HIT_W, 8, width of the hit counter and hit threshold.
- SETTLE, 2, cycles to wait after the threshold before sampling result_reg (writeback lag); legal range 1..15.

Ports:
- clk  in  1  core clock.
- cpurst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous restart to IDLE; zeroes counters and status.
- enable  in  1  start and count enable.
- trig_pc_vec  in  NUM_TRIG*PC_W  trigger PCs; channel k occupies bits [k*PC_W +: PC_W].
- trig_en  in  NUM_TRIG  per-channel trigger enable.
- hit_thresh  in  HIT_W  hits required to end the test; 0 is treated as 1.
- timeout_cycles  in  CNT_W  watchdog limit; 0 disables the watchdog.
- pass_value  in  XLEN  expected result value (1 for riscv-tests).
- retire_valid  in  1  instruction valid into execute.
- retire_pc  in  PC_W  PC of that instruction.
- result_reg  in  XLEN  live result register value (x3).
- busy  out  1  state is RUN or SETTLE.
- done  out  1  state is DONE; sticky.
- pass  out  1  done with result_reg equal to pass_value.
- fail  out  1  done with a mismatch or a timeout.
- timeout  out  1  done because of the watchdog.
- cycle_count  out  CNT_W  cycles spent in RUN/SETTLE.
- instret_count  out  CNT_W  retired instructions in RUN/SETTLE.
- hit_count  out  HIT_W  trigger hits.
- result_snap  out  XLEN  sampled result_reg.

Behaviour:
- Reset (async, cpurst_n=0):
  - State is IDLE.
  - All outputs and counters are 0.
  - Reset mid-test aborts immediately with no status.
- clear=1 at a clock edge: same effect as reset, synchronous. It has priority over all other events, including in DONE.
- State IDLE:
  - Moves to RUN on the first edge with enable=1.
  - No counting happens in IDLE.
- State RUN:
  - Counting occurs only on cycles with enable=1; enable=0 freezes counters and stays in RUN.
  - cycle_count increments by 1 per counted cycle.
  - instret_count increments by 1 per counted cycle with retire_valid=1.
  - All counters saturate at all-ones and never wrap.
- Hit rule:
  - A hit is retire_valid=1 and enable=1 and retire_pc == trig_pc_vec[k] with trig_en[k]=1, for any k.
  - A hit counts once per cycle even if several channels match.
  - hit_count increments by 1 per hit, saturating.
- Threshold: when a hit makes hit_count+1 >= max(hit_thresh,1), the next state is SETTLE and the settle counter loads SETTLE-1.
- Watchdog:
  - If timeout_cycles != 0 and the updated cycle_count reaches timeout_cycles, the next state is DONE with timeout=1 and fail=1.
  - result_snap captures result_reg on that edge.
  - If the threshold and the timeout occur on the same edge, the threshold wins (go to SETTLE).
- State SETTLE:
  - Counters keep running; further hits are still counted.
  - The watchdog is not checked.
  - The settle counter decrements each cycle.
  - On the edge where it is 0: result_snap <= result_reg; pass = (result_reg == pass_value); fail = !pass; state moves to DONE.
  - With SETTLE=1, the sample happens on the first SETTLE edge.
- State DONE:
  - All counters and status are frozen; done=1.
  - Only clear or reset exits DONE.
- Invariants:
  - pass, fail and timeout are 0 unless done=1.
  - pass and fail are mutually exclusive.
  - Outputs are registered; status appears one cycle after the deciding edge.

Decomposition:
- Shared package sim_mon_pkg holds:
  - the state enum (IDLE, RUN, SETTLE, DONE);
  - the default PC_WRITE_TOHOST constant 32'h0000_0086;
  - the default pass value of 1.
- One sub-module: sat_counter (parameter W; inputs inc and clr; saturating).
  - Instantiated for the cycle, instret and hit counters.

Test Plan:
- Pass path: NUM_TRIG=2, trig0=0x86 enabled, hit_thresh=8, result_reg=1, SETTLE=2; 8 retires at 0x86 -> SETTLE, then done=1, pass=1, result_snap=1, hit_count=8.
- Fail path: same stimulus with result_reg=5 -> done=1, fail=1, pass=0, result_snap=5.
- Watchdog: timeout_cycles=100 with no hits -> done=1, timeout=1, fail=1, cycle_count=100. In a separate run with the 8th hit landing at cycle 100 -> SETTLE, then pass, timeout=0.
- Multi-channel: trig0=0x86, trig1=0x200, both enabled, thresh=3; hits at 0x86, 0x200, 0x86 -> done after the third. Same-cycle dual match (trig1=0x86) counts 1.
- Saturation and freeze: CNT_W=4, 20 counted cycles -> cycle_count=15. enable=0 for 5 cycles -> counts unchanged. After DONE, further retires leave instret_count unchanged.
- Reset/clear: cpurst_n low mid-SETTLE -> all outputs 0 immediately. clear in DONE -> IDLE, counters 0. Next enable -> RUN.
